// File: rtl/dispatcher4_pipeline_pkg.sv
// Constants and helpers shared by both ends of the 4-port link (arbiter and dispatcher).
package dispatcher4_pipeline_pkg;

   localparam int unsigned NUM_PORTS = 4;
   localparam int unsigned DEST_W    = 2;

   // One-hot select for a destination index.
   function automatic logic [NUM_PORTS-1:0] dest_onehot(input logic [DEST_W-1:0] dest);
      return NUM_PORTS'(1) << dest;
   endfunction

endpackage

// File: rtl/dispatcher4_pipeline_out_slice.sv
// One downstream output register with valid/ready handshake and a load enable from S1.
module dispatcher4_pipeline_out_slice #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready_in,
   output logic             valid_out,
   output logic [WIDTH-1:0] data_out,
   output logic             load_ok_c
);

   // Free, or draining on this edge, so a new word can be taken.
   assign load_ok_c = !valid_out || ready_in;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_out <= 1'b0;
         data_out  <= '0;
      end else if (load) begin
         valid_out <= 1'b1;
         data_out  <= load_data;
      end else if (ready_in) begin
         // Drain clears valid only; payload holds its last value.
         valid_out <= 1'b0;
      end
   end

endmodule

// File: rtl/dispatcher4_pipeline.sv
// 1:4 pipelined dispatcher: input stage S1 routes each tagged word to one of four output registers.
module dispatcher4_pipeline
   import dispatcher4_pipeline_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid_in,
   input  logic [WIDTH-1:0]           data_in,
   input  logic [DEST_W-1:0]          dest_in,
   output logic                       ready_out,
   output logic [NUM_PORTS-1:0]       valid_out,
   output logic [NUM_PORTS*WIDTH-1:0] data_out,
   input  logic [NUM_PORTS-1:0]       ready_in
);

   logic                 s1_valid;
   logic [WIDTH-1:0]     s1_data;
   logic [DEST_W-1:0]    s1_dest;
   logic [NUM_PORTS-1:0] load_ok;
   logic [NUM_PORTS-1:0] load;
   logic                 s1_fire;
   logic                 accept;

   assign s1_fire   = s1_valid && load_ok[s1_dest];
   // Combinational from ready_in so S1 can refill on the same edge it empties.
   assign ready_out = rst && (!s1_valid || s1_fire);
   assign accept    = valid_in && ready_out;

   always_comb begin
      load = '0;
      if (s1_fire) begin
         load = dest_onehot(s1_dest);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_dest  <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_data  <= data_in;
         s1_dest  <= dest_in;
      end else if (s1_fire) begin
         s1_valid <= 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      dispatcher4_pipeline_out_slice #(
         .WIDTH(WIDTH)
      ) u_slice (
         .clk      (clk),
         .rst      (rst),
         .load     (load[i]),
         .load_data(s1_data),
         .ready_in (ready_in[i]),
         .valid_out(valid_out[i]),
         .data_out (data_out[i*WIDTH +: WIDTH]),
         .load_ok_c(load_ok[i])
      );
   end

endmodule
